// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
module booth_seq_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic [2*WIDTH-1:0]   Product,
   output logic                 ready,
   output logic                 busy
);

   // Operands carry one extra bit so unsigned values become non-negative signed values.
   localparam int unsigned E  = WIDTH + 1;
   localparam int unsigned CW = $clog2(E + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t         state_q;
   state_t         state_d;

   logic [E-1:0]   m_q;
   logic [E:0]     h_q;
   logic [E-1:0]   q_q;
   logic           q_m1_q;
   logic [CW-1:0]  cnt_q;

   logic           accept_c;
   logic           last_c;
   logic [E-1:0]   a_ext_c;
   logic [E-1:0]   b_ext_c;
   logic [E:0]     m_sext_c;
   logic [E:0]     h_add_c;
   logic [E:0]     h_nxt_c;
   logic [E-1:0]   q_nxt_c;
   logic           q_m1_nxt_c;

   assign accept_c = start && !busy;
   assign last_c   = (state_q == S_RUN) && (cnt_q == CW'(E - 1));
   assign a_ext_c  = is_signed ? {A[WIDTH-1], A} : {1'b0, A};
   assign b_ext_c  = is_signed ? {B[WIDTH-1], B} : {1'b0, B};
   assign m_sext_c = {m_q[E-1], m_q};

   // One Booth step: conditional add/subtract of M, then arithmetic shift of {H,Q,q_m1}.
   always_comb begin
      h_add_c = h_q;
      case ({q_q[0], q_m1_q})
         2'b01:   h_add_c = h_q + m_sext_c;
         2'b10:   h_add_c = h_q - m_sext_c;
         default: h_add_c = h_q;
      endcase
      h_nxt_c    = {h_add_c[E], h_add_c[E:1]};
      q_nxt_c    = {h_add_c[0], q_q[E-1:1]};
      q_m1_nxt_c = q_q[0];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; IDLE and DONE hold until a start is accepted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)  state_d = S_RUN;
         S_RUN:   if (last_c) state_d = S_DONE;
         S_DONE:  if (start)  state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_q     <= '0;
         h_q     <= '0;
         q_q     <= '0;
         q_m1_q  <= 1'b0;
         cnt_q   <= '0;
         Product <= '0;
         ready   <= 1'b0;
         busy    <= 1'b0;
      end else if (accept_c) begin
         m_q     <= a_ext_c;
         h_q     <= '0;
         q_q     <= b_ext_c;
         q_m1_q  <= 1'b0;
         cnt_q   <= '0;
         ready   <= 1'b0;
         busy    <= 1'b1;
      end else if (state_q == S_RUN) begin
         h_q    <= h_nxt_c;
         q_q    <= q_nxt_c;
         q_m1_q <= q_m1_nxt_c;
         cnt_q  <= cnt_q + CW'(1);
         if (last_c) begin
            // Exact product fits in 2*WIDTH bits, so the low bits of {H,Q} are the result.
            Product <= {h_nxt_c[WIDTH-2:0], q_nxt_c};
            ready   <= 1'b1;
            busy    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier at WIDTH=8 and WIDTH=16.
module tb_booth_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start8, sgn8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        rdy8, busy8;
   logic        start16, sgn16;
   logic [15:0] a16, b16;
   logic [31:0] p16;
   logic        rdy16, busy16;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   booth_seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
      .A(a8), .B(b8), .Product(p8), .ready(rdy8), .busy(busy8)
   );

   booth_seq_multiplier #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sgn16),
      .A(a16), .B(b16), .Product(p16), .ready(rdy16), .busy(busy16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference product: interpret operands in w bits, multiply as integers, keep 2w bits.
   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                           input bit s, input int w);
      longint av, bv, pr;
      logic [63:0] mask;
      av = longint'(a);
      bv = longint'(b);
      if (s && a[w-1]) av = av - (longint'(1) << w);
      if (s && b[w-1]) bv = bv - (longint'(1) << w);
      pr   = av * bv;
      mask = (64'(1) << (2 * w)) - 64'(1);
      return 32'(64'(pr) & mask);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one W=8 op, wait for ready within a bound, check latency and result.
   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input bit s, input logic [15:0] exp);
      int n;
      a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      a8 = ~a; b8 = b + 8'd3; sgn8 = ~s;
      n = 0;
      do begin tick(); n++; end while (!rdy8 && n < 50);
      chk({tag, "_lat"}, 32'(n), 32'd9);
      chk({tag, "_prod"}, 32'(p8), 32'(exp));
      chk({tag, "_busy"}, 32'(busy8), 32'd0);
   endtask

   task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input bit s, input logic [31:0] exp);
      int n;
      a16 = a; b16 = b; sgn16 = s; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      a16 = b; b16 = a;
      n = 0;
      do begin tick(); n++; end while (!rdy16 && n < 80);
      chk({tag, "_lat"}, 32'(n), 32'd17);
      chk({tag, "_prod"}, p16, exp);
   endtask

   initial begin
      logic [15:0] ra, rb;
      bit          rs;
      int          n;

      rst_n = 1'b0; start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
      start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
      start8 = 1'b1;
      tick(); tick();
      chk("rst_prod", 32'(p8), 32'd0);
      chk("rst_ready", 32'(rdy8), 32'd0);
      chk("rst_busy", 32'(busy8), 32'd0);
      start8 = 1'b0;
      rst_n = 1'b1;
      tick();

      run8("t1_minsq", 8'h80, 8'h80, 1'b1, 16'h4000);
      chk("t1_ready_hold", 32'(rdy8), 32'd1);
      tick(); tick();
      chk("t1_ready_held", 32'(rdy8), 32'd1);
      chk("t1_prod_held", 32'(p8), 32'h4000);
      run8("t2_uns_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
      run8("t2_sgn_ff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
      run8("t3_m1x1", 8'hFF, 8'h01, 1'b1, 16'hFFFF);
      run8("t3_zero", 8'h00, 8'h7F, 1'b1, 16'h0000);

      // Start while busy is ignored.
      a8 = 8'd3; b8 = 8'd5; sgn8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      chk("t4_ready_clr", 32'(rdy8), 32'd0);
      chk("t4_busy_set", 32'(busy8), 32'd1);
      tick(); tick();
      a8 = 8'd7; b8 = 8'd7; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      n = 3;
      do begin tick(); n++; end while (!rdy8 && n < 50);
      chk("t4_lat", 32'(n), 32'd9);
      chk("t4_prod", 32'(p8), 32'h000F);
      chk("t4_busy", 32'(busy8), 32'd0);

      // Mid-operation reset.
      a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      chk("t5_prod", 32'(p8), 32'd0);
      chk("t5_ready", 32'(rdy8), 32'd0);
      chk("t5_busy", 32'(busy8), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("t5_no_resume", 32'(busy8), 32'd0);
      run8("t5_after", 8'hF6, 8'd12, 1'b1, ref_mul(16'h00F6, 16'd12, 1'b1, 8));

      // Start held high: back-to-back operations.
      a8 = 8'd11; b8 = 8'd13; sgn8 = 1'b0; start8 = 1'b1;
      tick();
      a8 = 8'hFE; b8 = 8'h05; sgn8 = 1'b1;
      repeat (9) tick();
      chk("bb_ready1", 32'(rdy8), 32'd1);
      chk("bb_prod1", 32'(p8), 32'd143);
      tick();
      chk("bb_ready_drop", 32'(rdy8), 32'd0);
      chk("bb_busy2", 32'(busy8), 32'd1);
      chk("bb_prod_hold", 32'(p8), 32'd143);
      repeat (9) tick();
      start8 = 1'b0;
      chk("bb_ready2", 32'(rdy8), 32'd1);
      chk("bb_prod2", 32'(p8), 32'hFFF6);
      tick();

      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom_range(0, 255));
         rb = 16'($urandom_range(0, 255));
         rs = 1'($urandom_range(0, 1));
         run8("rnd8", ra[7:0], rb[7:0], rs, ref_mul(ra, rb, rs, 8));
      end

      run16("t6_w16", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
      run16("t6_w16_uns", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
      for (int i = 0; i < 16; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         run16("rnd16", ra, rb, rs, ref_mul(ra, rb, rs, 16));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
